// File: rtl/leitor_registradores.sv
// Register-file dump unit: snapshots the PC, then walks every register through a spare
// combinational read port and streams the values over a valid/ready handshake.
module leitor_registradores #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned LARGURA   = 32,
  parameter bit          INCLUI_PC = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inicia,
  input  logic [LARGURA-1:0]          endereco_pc,
  output logic [$clog2(NUM_REGS)-1:0] endereco_leitura,
  input  logic [LARGURA-1:0]          dado_leitura,
  output logic                        saida_valida,
  input  logic                        saida_pronta,
  output logic [LARGURA-1:0]          saida_dado,
  output logic [$clog2(NUM_REGS)-1:0] saida_indice,
  output logic                        saida_eh_pc,
  output logic                        ocupado,
  output logic                        concluido
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {StOcioso, StLe, StEnvia, StFim} estado_t;

  estado_t         estado;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   endereco_q;
  logic            le_na_partida;

  // Without the PC beat the start cycle doubles as the read of register 0, which keeps the
  // first register beat in the cycle right after the start.
  assign le_na_partida    = (estado == StOcioso) && inicia && !INCLUI_PC;
  assign endereco_leitura = le_na_partida ? '0 : endereco_q;
  assign ocupado          = (estado != StOcioso);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= StOcioso;
      idx          <= '0;
      endereco_q   <= '0;
      saida_valida <= 1'b0;
      saida_dado   <= '0;
      saida_indice <= '0;
      saida_eh_pc  <= 1'b0;
      concluido    <= 1'b0;
    end else begin
      concluido <= 1'b0;
      unique case (estado)
        StOcioso: begin
          if (inicia) begin
            idx          <= '0;
            saida_indice <= '0;
            saida_valida <= 1'b1;
            estado       <= StEnvia;
            if (INCLUI_PC) begin
              saida_dado  <= endereco_pc;
              saida_eh_pc <= 1'b1;
            end else begin
              endereco_q  <= '0;
              saida_dado  <= dado_leitura;
              saida_eh_pc <= 1'b0;
            end
          end
        end
        StLe: begin
          saida_dado   <= dado_leitura;
          saida_indice <= idx;
          saida_eh_pc  <= 1'b0;
          saida_valida <= 1'b1;
          estado       <= StEnvia;
        end
        StEnvia: begin
          if (saida_pronta) begin
            saida_valida <= 1'b0;
            if (saida_eh_pc) begin
              idx        <= '0;
              endereco_q <= '0;
              estado     <= StLe;
            end else if (idx == IW'(NUM_REGS - 1)) begin
              concluido <= 1'b1;
              estado    <= StFim;
            end else begin
              idx        <= idx + 1'b1;
              endereco_q <= idx + 1'b1;
              estado     <= StLe;
            end
          end
        end
        StFim: begin
          estado <= StOcioso;
        end
        default: estado <= StOcioso;
      endcase
    end
  end

endmodule
